serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial multi-bit adder built around a single full-adder cell plus a registered carry. It accepts two WIDTH-bit operands and a carry-in through a start/ready handshake. It adds them LSB-first, one bit per clock, then presents the sum and carry-out under a valid/ack handshake. It is the sequential stage that consumes the full adder's sum/c_out each cycle, and the area-lean alternative to a ripple-carry array.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an addition; accepted only when ready=1.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
c_in  input  1  carry into bit 0; sampled on the accepting edge only.
ready  output  1  block idle and able to accept start.
busy  output  1  addition in progress.
result_valid  output  1  sum/c_out hold a completed result.
result_ack  input  1  consumer accepts the result; honoured only while result_valid=1.
sum  output  WIDTH  registered result of a+b+c_in, modulo 2^WIDTH.
c_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, RUN, DONE. Outputs decoded from state: ready=(IDLE), busy=(RUN), result_valid=(DONE).
- Reset: on any edge with rst=1, state<=IDLE; operand shift regs, carry reg, bit counter, sum and c_out cleared to 0. Reset wins over every other input. Reset during RUN aborts the operation; result_valid does not assert for it.
- IDLE: on an edge with start=1, load a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0 and move to RUN. This is the accepting edge (edge 0). With start=0, remain in IDLE.
- RUN, each edge:
  - bit = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - acc <= {bit, acc[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - cnt increments.
- RUN exit: on the edge where cnt==WIDTH-1, that final bit is processed, sum<={bit, acc[WIDTH-1:1]}, c_out<=final carry, and the state moves to DONE.
- Latency: exactly WIDTH edges in RUN. result_valid is first high after edge WIDTH, counting the accepting edge as 0.
- start is ignored in RUN and DONE. Operand changes after edge 0 have no effect.
- DONE: sum/c_out stay stable until result_ack=1 is sampled, then state<=IDLE on that edge. result_ack outside DONE is ignored.
- Back-to-back: after ack, ready=1 the next cycle, so start may be accepted one edge after the ack edge. There is no IDLE bypass from DONE.
- sum and c_out update only on the edge entering DONE. They retain their value through IDLE and RUN until the next completion or reset.
- Width rules: cnt is clog2(WIDTH)+1 bits wide. For WIDTH=1, RUN lasts one edge. The result always satisfies {c_out,sum} == a+b+c_in, as a (WIDTH+1)-bit value.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 -> after release ready=1, busy=0, result_valid=0, sum=0x00, c_out=0.
2. WIDTH=8, a=0x0F, b=0x01, c_in=0, start pulsed -> busy for 8 cycles; result_valid rises after edge 8 with sum=0x10, c_out=0.
3. Carry chain: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
4. Handshake:
   - Hold result_ack=0 for 5 cycles -> result_valid and sum stay stable.
   - start pulses during RUN/DONE and operand changes after edge 0 -> no effect.
   - Ack -> ready=1 next cycle; an immediate new start completes correctly.
5. Reset mid-operation: assert rst on edge 4 of RUN -> IDLE, result_valid never asserts, sum=0; a following add of 0x12+0x34 gives sum=0x46.
6. WIDTH=1 build: all 8 (a,b,c_in) combinations -> sum/c_out match the full-adder truth table, result_valid one edge after acceptance. WIDTH=8: 1000 random operands checked against the a+b+c_in reference model.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operand request (start/ready)
// on one side, result delivery (result_valid/result_ack) on the other.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic             result_ack;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in, result_ack,
    input  ready, busy, result_valid, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in, result_ack,
    output ready, busy, result_valid, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first,
// one bit per clock, with start/ready intake and valid/ack result delivery.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             c_out_q;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = majority(a_sh[0], b_sh[0], carry);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  // The accumulator fills from the top so the final bit lands in the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign acc_nxt = sum_bit;
    end else begin : g_wn
      assign acc_nxt = {sum_bit, acc[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start)      state_nxt = RUN;
      RUN:     if (last_bit)       state_nxt = DONE;
      DONE:    if (bus.result_ack) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        carry <= bus.c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= carry_nxt;
        acc   <= acc_nxt;
        cnt   <= cnt + CNT_W'(1);
        // sum/c_out only move on completion and hold through IDLE and RUN.
        if (last_bit) begin
          sum_q   <= acc_nxt;
          c_out_q <= carry_nxt;
        end
      end
    end
  end

  assign bus.ready        = (state == IDLE);
  assign bus.busy         = (state == RUN);
  assign bus.result_valid = (state == DONE);
  assign bus.sum          = sum_q;
  assign bus.c_out        = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1, with a
// queue of expected {c_out,sum} values pushed on acceptance and popped on completion.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int total  = 0;
  int passed = 0;
  logic [W:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic start8(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    check("ready_before_start", {63'd0, bus8.ready}, 64'd1);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.c_in = ci;
    @(posedge clk);
    sb_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(ci));
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = W'($urandom); bus8.b = W'($urandom); bus8.c_in = 1'($urandom);
  endtask

  task automatic wait_result8(input string tag);
    int lat = 0;
    int busy_cnt = 0;
    logic [W:0] exp;
    while (bus8.result_valid !== 1'b1 && lat < 4 * W) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    if (bus8.result_valid === 1'b1) begin
      check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check({tag, "_result"}, {55'd0, bus8.c_out, bus8.sum}, {55'd0, exp});
      end
    end else begin
      sb_q.delete();
    end
  endtask

  task automatic ack8(input string tag);
    bus8.result_ack = 1'b1;
    @(negedge clk);
    bus8.result_ack = 1'b0;
    check({tag, "_ready_after_ack"}, {62'd0, bus8.ready, bus8.result_valid}, 64'b10);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic [1:0]   exp1;
    int           seen_valid;

    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.c_in = 1'b1; bus8.result_ack = 1'b0;
    bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.c_in = 1'b0; bus1.result_ack = 1'b0;

    // Reset with start held high
    repeat (2) @(negedge clk);
    rst = 1'b0; bus8.start = 1'b0;
    check("reset_ctrl", {61'd0, bus8.ready, bus8.busy, bus8.result_valid}, 64'b100);
    check("reset_result", {55'd0, bus8.c_out, bus8.sum}, 64'd0);

    // Basic add
    start8(8'h0F, 8'h01, 1'b0);
    wait_result8("add_0f_01");
    ack8("add_0f_01");

    // Carry chain cases
    start8(8'hFF, 8'h01, 1'b0);
    wait_result8("carry_ff_01");
    ack8("carry_ff_01");
    check("sum_held_in_idle", {55'd0, bus8.c_out, bus8.sum}, 64'h100);
    start8(8'hFF, 8'hFF, 1'b1);
    check("sum_held_in_run", {55'd0, bus8.c_out, bus8.sum}, 64'h100);
    wait_result8("carry_ff_ff_1");
    ack8("carry_ff_ff_1");

    // Handshake: start pulses in RUN/DONE, operand noise, stalled ack
    start8(8'h3C, 8'h42, 1'b1);
    repeat (2) begin
      bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
      @(negedge clk);
    end
    bus8.start = 1'b0;
    while (bus8.result_valid !== 1'b1 && total < 100000) @(negedge clk);
    check("stall_result", {55'd0, bus8.c_out, bus8.sum}, 64'h07F);
    held_sum = bus8.sum;
    bus8.start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid_stable", {62'd0, bus8.result_valid, bus8.ready}, 64'b10);
      check("stall_sum_stable", {56'd0, bus8.sum}, {56'd0, held_sum});
    end
    bus8.start = 1'b0;
    void'(sb_q.pop_front());
    ack8("stall");
    start8(8'h80, 8'h80, 1'b0);
    wait_result8("back_to_back");
    ack8("back_to_back");

    // Reset sampled on edge 4 of RUN aborts the operation
    start8(8'hAA, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    check("midrst_ctrl", {61'd0, bus8.ready, bus8.busy, bus8.result_valid}, 64'b100);
    check("midrst_result", {55'd0, bus8.c_out, bus8.sum}, 64'd0);
    seen_valid = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus8.result_valid === 1'b1) seen_valid++;
    end
    check("midrst_no_valid", 64'(seen_valid), 64'd0);
    start8(8'h12, 8'h34, 1'b0);
    wait_result8("after_midrst");
    ack8("after_midrst");

    // WIDTH=1 instance: full-adder truth table, one RUN edge
    for (int i = 0; i < 8; i++) begin
      bus1.a = 1'(i >> 2); bus1.b = 1'(i >> 1); bus1.c_in = 1'(i);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      exp1 = 2'(i >> 2 & 1) + 2'(i >> 1 & 1) + 2'(i & 1);
      check("w1_run", {62'd0, bus1.busy, bus1.result_valid}, 64'b10);
      @(negedge clk);
      check("w1_valid", {63'd0, bus1.result_valid}, 64'd1);
      check("w1_result", {62'd0, bus1.c_out, bus1.sum}, {62'd0, exp1});
      bus1.result_ack = 1'b1;
      @(negedge clk);
      bus1.result_ack = 1'b0;
    end

    // Random operands against the a+b+c_in model
    for (int n = 0; n < 1000; n++) begin
      start8(W'($urandom), W'($urandom), 1'($urandom));
      wait_result8("random");
      ack8("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
